sobel_window_gen: RTL and testbench

Raster-scan front end for the Sobel datapath, on the producer side of the six-tap convolver interface.
- Accepts one pixel per valid cycle and keeps the two previous image rows in internal line buffers.
- Maintains a 3x3 neighbourhood and drives the six column taps for the Gx convolver and the six row taps for the Gy convolver, plus a shared valid_data.
- Emits interior windows only; no border padding.

---
 rtl/sobel_window_gen.sv | 87 ++++++++
 tb/tb_sobel_window_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster 3x3 window generator feeding Gx/Gy six-tap convolvers; `FRAME_CNT_EN adds frame_count
module sobel_window_gen #(
  parameter int data_size = 24,
  parameter int img_width = 640,
  parameter int img_height = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_valid,
  input  logic [data_size-1:0] pixel_in,
  output logic [data_size-1:0] gx_p1a,
  output logic [data_size-1:0] gx_p2,
  output logic [data_size-1:0] gx_p1b,
  output logic [data_size-1:0] gx_m1a,
  output logic [data_size-1:0] gx_m2,
  output logic [data_size-1:0] gx_m1b,
  output logic [data_size-1:0] gy_p1a,
  output logic [data_size-1:0] gy_p2,
  output logic [data_size-1:0] gy_p1b,
  output logic [data_size-1:0] gy_m1a,
  output logic [data_size-1:0] gy_m2,
  output logic [data_size-1:0] gy_m1b,
`ifdef FRAME_CNT_EN
  output logic [15:0]          frame_count,
`endif
  output logic                 valid_data,
  output logic                 frame_done
);
  localparam int cw = $clog2(img_width);
  localparam int rw = $clog2(img_height);
  logic [cw-1:0] col;
  logic [rw-1:0] row;
  logic [data_size-1:0] lb_top [img_width];
  logic [data_size-1:0] lb_mid [img_width];
  logic [data_size-1:0] w [3][3];
  logic last_col, last_row, take;
  assign last_col = col == cw'(img_width - 1);
  assign last_row = row == rw'(img_height - 1);
  assign take = pixel_valid && !rst;
  always_ff @(posedge clk)
    if (take) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pixel_in;
    end
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
      valid_data <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] <= '0;
    end else if (pixel_valid) begin
      for (int i = 0; i < 3; i++) begin
        w[i][0] <= w[i][1];
        w[i][1] <= w[i][2];
      end
      w[0][2] <= lb_top[col];
      w[1][2] <= lb_mid[col];
      w[2][2] <= pixel_in;
      valid_data <= row >= rw'(2) && col >= cw'(2);
      frame_done <= last_col && last_row;
      col <= last_col ? '0 : col + cw'(1);
      row <= last_col ? (last_row ? '0 : row + rw'(1)) : row;
    end else begin
      valid_data <= 1'b0;
      frame_done <= 1'b0;
    end
`ifdef FRAME_CNT_EN
  always_ff @(posedge clk)
    if (rst) frame_count <= '0;
    else if (pixel_valid && last_col && last_row) frame_count <= frame_count + 16'd1;
`endif
  assign gx_p1a = w[0][2];
  assign gx_p2  = w[1][2];
  assign gx_p1b = w[2][2];
  assign gx_m1a = w[0][0];
  assign gx_m2  = w[1][0];
  assign gx_m1b = w[2][0];
  assign gy_p1a = w[2][0];
  assign gy_p2  = w[2][1];
  assign gy_p1b = w[2][2];
  assign gy_m1a = w[0][0];
  assign gy_m2  = w[0][1];
  assign gy_m1b = w[0][2];
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: randomized and directed check of sobel_window_gen against an image-array model
module tb_sobel_window_gen;
  localparam int W = 4, H = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, valid, rst3, valid3;
  logic [7:0] pix, pix3;
  logic [7:0] t [12];
  logic [7:0] u [12];
  logic vd, fd, vd3, fd3;
`ifdef FRAME_CNT_EN
  logic [15:0] fc, fc3;
`endif
  int checks = 0, errors = 0;
  logic [7:0] img [H][W];
  int mr = 0, mc = 0, wins = 0, frames = 0;

  sobel_window_gen #(.data_size(8), .img_width(W), .img_height(H)) dut (
    .clk(clk), .rst(rst), .pixel_valid(valid), .pixel_in(pix),
    .gx_p1a(t[0]), .gx_p2(t[1]), .gx_p1b(t[2]), .gx_m1a(t[3]), .gx_m2(t[4]), .gx_m1b(t[5]),
    .gy_p1a(t[6]), .gy_p2(t[7]), .gy_p1b(t[8]), .gy_m1a(t[9]), .gy_m2(t[10]), .gy_m1b(t[11]),
`ifdef FRAME_CNT_EN
    .frame_count(fc),
`endif
    .valid_data(vd), .frame_done(fd));

  sobel_window_gen #(.data_size(8), .img_width(3), .img_height(3)) dut3 (
    .clk(clk), .rst(rst3), .pixel_valid(valid3), .pixel_in(pix3),
    .gx_p1a(u[0]), .gx_p2(u[1]), .gx_p1b(u[2]), .gx_m1a(u[3]), .gx_m2(u[4]), .gx_m1b(u[5]),
    .gy_p1a(u[6]), .gy_p2(u[7]), .gy_p1b(u[8]), .gy_m1a(u[9]), .gy_m2(u[10]), .gy_m1b(u[11]),
`ifdef FRAME_CNT_EN
    .frame_count(fc3),
`endif
    .valid_data(vd3), .frame_done(fd3));

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pack(input logic [7:0] a [12]);
    return {a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7], a[8], a[9], a[10], a[11]};
  endfunction

  task automatic step(input logic v, input logic [7:0] p, input logic r);
    logic ev, ed;
    logic [7:0] e [12];
    @(negedge clk);
    valid = v; pix = p; rst = r;
    @(posedge clk);
    #1;
    ev = 0; ed = 0;
    if (r) begin
      mr = 0; mc = 0; wins = 0; frames = 0;
      check("reset_taps", pack(t), 96'd0);
    end else if (v) begin
      img[mr][mc] = p;
      ev = mr >= 2 && mc >= 2;
      ed = mr == H - 1 && mc == W - 1;
      if (ev) begin
        e = '{img[mr-2][mc], img[mr-1][mc], img[mr][mc],
              img[mr-2][mc-2], img[mr-1][mc-2], img[mr][mc-2],
              img[mr][mc-2], img[mr][mc-1], img[mr][mc],
              img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc]};
        check("taps", pack(t), pack(e));
        wins++;
      end
      if (ed) begin
        check("windows_per_frame", 96'(wins), 96'((W - 2) * (H - 2)));
        wins = 0;
        frames++;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = mr + 1 == H ? 0 : mr + 1;
      end
    end
    check("valid_data", 96'(vd), 96'(ev));
    check("frame_done", 96'(fd), 96'(ed));
`ifdef FRAME_CNT_EN
    check("frame_count", 96'(fc), 96'(frames[15:0]));
`endif
  endtask

  task automatic step3(input logic v, input logic [7:0] p, input logic r);
    @(negedge clk);
    valid3 = v; pix3 = p; rst3 = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; valid = 0; pix = 0; rst3 = 1; valid3 = 0; pix3 = 0;
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i + 1), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i + 1), 0);
      if (i % 2 == 1) for (int g = 0; g < 3; g++) step(0, 8'hEE, 0);
    end
    for (int i = 0; i < 9; i++) step(1, 8'(i + 50), 0);
    step(0, 0, 1);
    check("reset_valid", 96'(vd), 96'd0);
    for (int i = 0; i < 16; i++) step(1, 8'(i + 1), 0);
    for (int i = 0; i < 16; i++) step(1, 8'(100 + i), 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) step(0, 0, 1);
      else step($urandom_range(0, 9) < 7, 8'($urandom), 0);
    end
    step3(0, 0, 1);
    check("w3_reset_taps", pack(u), 96'd0);
    for (int i = 1; i <= 9; i++) begin
      step3(1, 8'(i), 0);
      check("w3_valid", 96'(vd3), 96'(i == 9));
      check("w3_done", 96'(fd3), 96'(i == 9));
    end
    check("w3_taps", pack(u), {8'd3, 8'd6, 8'd9, 8'd1, 8'd4, 8'd7, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3});
    step3(0, 0, 0);
    check("w3_idle_valid", 96'(vd3), 96'd0);
    check("w3_idle_done", 96'(fd3), 96'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
